// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared state type, widths and peripheral map for the Wishbone master bridge
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;

  localparam logic [31:0] WB_GPIO_BASE    = 32'h8000_1000;
  localparam logic [31:0] WB_GPIO_ODR_OFS = 32'h0000_0004;
  localparam logic [31:0] WB_GPIO_IDR_OFS = 32'h0000_0000;

  // Read data returned when a transaction is abandoned by the bus timeout
  localparam logic [31:0] WB_TIMEOUT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/wb_timeout_ctr.sv
// rtl/wb_timeout_ctr.sv - bus-cycle counter, instantiated only when WB_MASTER_TIMEOUT_EN is defined
// expired is high while the count equals LIMIT-1.
module wb_timeout_ctr #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// rtl/wb_master_bridge.sv - single-beat valid/ready to Wishbone B4 classic initiator
// Optional bus timeout enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_W         = WB_ADDR_W,
  parameter int unsigned DATA_W         = WB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                iclk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_we,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic                wb_we_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_stb_o,
  output logic                wb_cyc_o,
  input  logic                wb_ack_i,
  input  logic                wb_err_i
);

  localparam int unsigned SEL_W = DATA_W / 8;

  wb_state_e         state_q,     state_d;
  logic [ADDR_W-1:0] adr_q,       adr_d;
  logic [DATA_W-1:0] dat_q,       dat_d;
  logic              we_q,        we_d;
  logic [SEL_W-1:0]  sel_q,       sel_d;
  logic              bus_q,       bus_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              tmo_expired;

`ifdef WB_MASTER_TIMEOUT_EN
  logic tmo_clr;
  logic tmo_en;

  // Held clear outside BUS so every transaction starts counting from zero
  assign tmo_clr = (state_q != BUS);
  assign tmo_en  = (state_q == BUS) && !wb_ack_i && !wb_err_i;

  wb_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (iclk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    sel_d       = sel_q;
    bus_d       = bus_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          adr_d       = req_addr;
          dat_d       = req_wdata;
          we_d        = req_we;
          sel_d       = req_sel;
          bus_d       = 1'b1;
          req_ready_d = 1'b0;
          state_d     = BUS;
        end
      end
      BUS: begin
        // err outranks ack, and both outrank the timeout on the final cycle
        if (wb_err_i) begin
          bus_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else if (wb_ack_i) begin
          bus_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? '0 : wb_dat_i;
          state_d     = RESP;
        end else if (tmo_expired) begin
          bus_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = DATA_W'(WB_TIMEOUT_RDATA);
          state_d     = RESP;
        end
      end
      RESP: begin
        // req_ready rises only after this edge, so no request is taken on the handshake edge
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        bus_d       = 1'b0;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge iclk) begin
    if (rst) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      bus_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      bus_q       <= bus_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign wb_cyc_o  = bus_q;
  assign wb_stb_o  = bus_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// tb/tb_wb_master_bridge.sv - scoreboard bench for wb_master_bridge; honours WB_MASTER_TIMEOUT_EN
`timescale 1ns/1ps
module tb_wb_master_bridge;
  import wb_pkg::*;

  localparam int unsigned TMO = 8;
  localparam logic [31:0] ODR_ADDR = WB_GPIO_BASE + WB_GPIO_ODR_OFS;
  localparam logic [31:0] IDR_ADDR = WB_GPIO_BASE + WB_GPIO_IDR_OFS;

  logic        iclk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;

  // Responder: 0 silent, 1 ack once, 2 ack re-registered (late ack), 3 err on 3rd bus cycle
  int          resp_mode = 1;
  int          bus_cnt = 0;
  logic [15:0] gpio_odr = '0;
  logic [15:0] gpio_idr = '0;

  always #5 iclk = ~iclk;

  wb_master_bridge #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .iclk(iclk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always @(posedge iclk) begin
    wb_ack_i <= 1'b0;
    wb_err_i <= 1'b0;
    if (wb_cyc_o && wb_stb_o) bus_cnt <= bus_cnt + 1;
    else bus_cnt <= 0;
    if (wb_cyc_o && wb_stb_o) begin
      if ((resp_mode == 1 && !wb_ack_i) || resp_mode == 2) begin
        wb_ack_i <= 1'b1;
        if (wb_we_o && wb_adr_o == ODR_ADDR) gpio_odr <= wb_dat_o[15:0];
        if (wb_adr_o == IDR_ADDR) wb_dat_i <= {16'h0, gpio_idr};
        else if (wb_adr_o == ODR_ADDR) wb_dat_i <= {16'h0, gpio_odr};
        else wb_dat_i <= 32'hDEAD_BEEF;
      end else if (resp_mode == 3 && bus_cnt == 1) begin
        wb_err_i <= 1'b1;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d, input bit keep_valid,
                       output int bus_cycles, output bit rsp_now, output bit ok);
    int n;
    @(negedge iclk);
    req_valid = 1'b1; req_addr = a; req_we = w; req_wdata = d; req_sel = 4'hF;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge iclk); n++; end
    @(negedge iclk);
    if (!keep_valid) req_valid = 1'b0;
    bus_cycles = 0;
    while (wb_cyc_o && wb_stb_o && bus_cycles < 1000) begin bus_cycles++; @(negedge iclk); end
    rsp_now = rsp_valid;
    ok = (n < 50);
  endtask

  task automatic take_rsp(output logic [31:0] rd, output logic er, output bit ok);
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge iclk); n++; end
    ok = rsp_valid;
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(negedge iclk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge iclk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b, want 1 0", req_ready, rsp_valid);
    end
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0) begin
      errors++; $display("FAIL reset_bus_ctl: cyc=%b stb=%b we=%b, want 0 0 0", wb_cyc_o, wb_stb_o, wb_we_o);
    end
    checks++;
    if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0 || wb_sel_o !== 4'h0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_data: adr=%h dat=%h sel=%h rdata=%h err=%b, want all 0",
                         wb_adr_o, wb_dat_o, wb_sel_o, rsp_rdata, rsp_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_write();
    int bc; bit rn, ok; logic [31:0] rd; logic er; exp_t e;
    resp_mode = 1;
    sb_q.push_back('{rdata: 32'h0, err: 1'b0});
    issue(ODR_ADDR, 1'b1, 32'h0000_A5A5, 1'b0, bc, rn, ok);
    checks++;
    if (bc !== 2 || !ok) begin errors++; $display("FAIL write_cyc_cycles: got %0d ok=%b, want 2", bc, ok); end
    checks++;
    if (rn !== 1'b1) begin errors++; $display("FAIL write_latency: rsp_valid=%b when cyc dropped, want 1", rn); end
    take_rsp(rd, er, ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || rd !== e.rdata || er !== e.err) begin
      errors++; $display("FAIL write_rsp: rdata=%h err=%b, want %h %b", rd, er, e.rdata, e.err);
    end
    checks++;
    if (gpio_odr !== 16'hA5A5) begin errors++; $display("FAIL write_gpio_odr: got %h, want a5a5", gpio_odr); end
  endtask

  task automatic test_read();
    int bc; bit rn, ok; logic [31:0] rd; logic er; exp_t e;
    resp_mode = 1;
    gpio_idr = 16'h1234;
    sb_q.push_back('{rdata: 32'h0000_1234, err: 1'b0});
    issue(IDR_ADDR, 1'b0, 32'hFFFF_0000, 1'b0, bc, rn, ok);
    checks++;
    if (bc !== 2 || rn !== 1'b1) begin errors++; $display("FAIL read_timing: cyc=%0d rsp_now=%b, want 2 1", bc, rn); end
    take_rsp(rd, er, ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || rd !== e.rdata || er !== e.err) begin
      errors++; $display("FAIL read_rsp: rdata=%h err=%b, want %h %b", rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_error();
    int bc; bit rn, ok; logic [31:0] rd; logic er; exp_t e;
    resp_mode = 3;
    sb_q.push_back('{rdata: 32'h0, err: 1'b1});
    issue(IDR_ADDR, 1'b0, 32'h0, 1'b0, bc, rn, ok);
    checks++;
    if (bc !== 3 || rn !== 1'b1) begin errors++; $display("FAIL err_timing: cyc=%0d rsp_now=%b, want 3 1", bc, rn); end
    take_rsp(rd, er, ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || rd !== e.rdata || er !== e.err) begin
      errors++; $display("FAIL err_rsp: rdata=%h err=%b, want %h %b", rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_backpressure();
    int bc, n; bit rn, ok; logic [31:0] rd0, rd; logic er0, er; exp_t e;
    resp_mode = 2;
    gpio_idr = 16'h00C3;
    sb_q.push_back('{rdata: 32'h0000_00C3, err: 1'b0});
    sb_q.push_back('{rdata: 32'h0000_00C3, err: 1'b0});
    issue(IDR_ADDR, 1'b0, 32'h0, 1'b1, bc, rn, ok);
    rd0 = rsp_rdata; er0 = rsp_err;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || wb_cyc_o !== 1'b0 || rsp_rdata !== rd0 || rsp_err !== er0) begin
        errors++; $display("FAIL bp_hold cycle %0d: valid=%b ready=%b cyc=%b rdata=%h, want 1 0 0 %h",
                           i, rsp_valid, req_ready, wb_cyc_o, rsp_rdata, rd0);
      end
      @(negedge iclk);
    end
    rsp_ready = 1'b1;
    @(negedge iclk);
    rsp_ready = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if (rd0 !== e.rdata || er0 !== e.err) begin
      errors++; $display("FAIL bp_rsp1: rdata=%h err=%b, want %h %b", rd0, er0, e.rdata, e.err);
    end
    checks++;
    if (rsp_valid !== 1'b0 || wb_cyc_o !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_after_hs: valid=%b cyc=%b ready=%b, want 0 0 1", rsp_valid, wb_cyc_o, req_ready);
    end
    @(negedge iclk);
    req_valid = 1'b0;
    checks++;
    if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL bp_reaccept: cyc=%b, want 1", wb_cyc_o); end
    n = 0;
    while (wb_cyc_o && n < 50) begin @(negedge iclk); n++; end
    take_rsp(rd, er, ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || rd !== e.rdata || er !== e.err) begin
      errors++; $display("FAIL bp_rsp2: rdata=%h err=%b, want %h %b", rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_back_to_back();
    int bc; bit rn, ok; logic [31:0] rd, d; logic er, w; exp_t e;
    logic [15:0] exp_odr;
    resp_mode = 1;
    exp_odr = gpio_odr;
    for (int i = 0; i < 8; i++) begin
      w = (i % 3 != 2);
      d = $urandom;
      if (w) begin
        exp_odr = d[15:0];
        sb_q.push_back('{rdata: 32'h0, err: 1'b0});
      end else begin
        sb_q.push_back('{rdata: {16'h0, exp_odr}, err: 1'b0});
      end
      issue(ODR_ADDR, w, d, 1'b0, bc, rn, ok);
      take_rsp(rd, er, ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok || bc !== 2 || rd !== e.rdata || er !== e.err) begin
        errors++; $display("FAIL b2b_%0d: cyc=%0d rdata=%h err=%b, want 2 %h %b", i, bc, rd, er, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_timeout();
    int bc; bit rn, ok;
`ifdef WB_MASTER_TIMEOUT_EN
    logic [31:0] rd; logic er; exp_t e;
    resp_mode = 0;
    sb_q.push_back('{rdata: 32'hFFFF_FFFF, err: 1'b1});
    issue(32'h8000_2000, 1'b0, 32'h0, 1'b0, bc, rn, ok);
    checks++;
    if (bc !== TMO || rn !== 1'b1) begin errors++; $display("FAIL timeout_cycles: cyc=%0d rsp_now=%b, want %0d 1", bc, rn, TMO); end
    take_rsp(rd, er, ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || rd !== e.rdata || er !== e.err) begin
      errors++; $display("FAIL timeout_rsp: rdata=%h err=%b, want %h %b", rd, er, e.rdata, e.err);
    end
`else
    resp_mode = 0;
    issue(32'h8000_2000, 1'b0, 32'h0, 1'b0, bc, rn, ok);
    checks++;
    if (bc !== 1000 || wb_cyc_o !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL no_timeout_hold: cyc_cycles=%0d cyc=%b valid=%b, want 1000 1 0", bc, wb_cyc_o, rsp_valid);
    end
    rst = 1'b1;
    @(negedge iclk);
    rst = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_bus();
    int n; bit seen;
    resp_mode = 0;
    @(negedge iclk);
    req_valid = 1'b1; req_addr = IDR_ADDR; req_we = 1'b0; req_sel = 4'hF;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge iclk); n++; end
    @(negedge iclk);
    req_valid = 1'b0;
    @(negedge iclk);
    checks++;
    if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL rst_mid_setup: cyc=%b, want 1", wb_cyc_o); end
    rst = 1'b1;
    resp_mode = 1;
    @(negedge iclk);
    rst = 1'b0;
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_abort: cyc=%b stb=%b valid=%b ready=%b, want 0 0 0 1",
                         wb_cyc_o, wb_stb_o, rsp_valid, req_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid || wb_cyc_o) seen = 1'b1;
      @(negedge iclk);
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_rsp: activity=%b after abort, want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_error();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
